// File: rtl/mem_bank_pipe_if.sv
// ---------------------------------------------------------------------------
// mem_bank_pipe_if
// Request/response bus for the pipelined memory bank.
//   master : drives req_valid/req_we/req_addr/req_wdata/req_wstrb and
//            rsp_ready; observes req_ready and the rsp_* response signals.
//   slave  : the memory bank side of the same bus.
// DATA_W must be a multiple of 8 (one strobe bit per byte).
// ---------------------------------------------------------------------------
interface mem_bank_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_bank_pipe.sv
// ---------------------------------------------------------------------------
// mem_bank_pipe
// Single-port word memory with byte-strobed writes and pipelined reads.
// Reads travel through an RD_LAT-cycle pipeline into a RSP_DEPTH-entry
// response FIFO; the number of outstanding reads is capped at RSP_DEPTH so
// the FIFO can never overflow. Writes produce no response.
// Ports:
//   ACLK    : clock, rising edge
//   ARESETn : asynchronous active-low reset (memory array is not reset)
//   bus     : mem_bank_pipe_if slave modport (req_* in, rsp_* out)
// ---------------------------------------------------------------------------
module mem_bank_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    mem_bank_pipe_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  outstanding;
    logic              addr_ok;
    logic              req_fire;
    logic              rd_fire;
    logic              wr_fire;
    logic              rsp_fire;
    logic [DATA_W-1:0] rd_data_in;
    logic              rd_err_in;

    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_wr_err;
    logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
    logic              fifo_err  [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              rsp_valid_int;

    // Pointer increment with explicit wrap so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign addr_ok  = {1'b0, bus.req_addr} < DEPTH_L;
    assign bus.req_ready = ARESETn && (outstanding < CNT_MAX);
    assign req_fire = bus.req_valid && bus.req_ready;
    assign rd_fire  = req_fire && !bus.req_we;
    assign wr_fire  = req_fire && bus.req_we && addr_ok;
    assign rsp_fire = rsp_valid_int && bus.rsp_ready;

    // Out-of-range reads return zero data flagged with an error.
    assign rd_data_in = addr_ok ? mem[bus.req_addr] : '0;
    assign rd_err_in  = !addr_ok;

    // Byte-strobed write; the array itself is never reset.
    always_ff @(posedge ACLK) begin
        if (wr_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.req_wstrb[b]) begin
                    mem[bus.req_addr][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reads in flight anywhere (pipeline or FIFO); caps acceptance.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            outstanding <= '0;
        end else if (rd_fire && !rsp_fire) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!rd_fire && rsp_fire) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    // The memory sample at the accept edge counts as the first latency
    // cycle, so only RD_LAT-1 extra register stages precede the FIFO.
    generate
        if (RD_LAT == 1) begin : g_direct
            assign fifo_wr_en   = rd_fire;
            assign fifo_wr_data = rd_data_in;
            assign fifo_wr_err  = rd_err_in;
        end else begin : g_pipe
            logic              pipe_valid [RD_LAT-1];
            logic [DATA_W-1:0] pipe_data  [RD_LAT-1];
            logic              pipe_err   [RD_LAT-1];

            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    for (int i = 0; i < RD_LAT-1; i++) begin
                        pipe_valid[i] <= 1'b0;
                        pipe_data[i]  <= '0;
                        pipe_err[i]   <= 1'b0;
                    end
                end else begin
                    pipe_valid[0] <= rd_fire;
                    pipe_data[0]  <= rd_data_in;
                    pipe_err[0]   <= rd_err_in;
                    for (int i = 1; i < RD_LAT-1; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_data[i]  <= pipe_data[i-1];
                        pipe_err[i]   <= pipe_err[i-1];
                    end
                end
            end

            assign fifo_wr_en   = pipe_valid[RD_LAT-2];
            assign fifo_wr_data = pipe_data[RD_LAT-2];
            assign fifo_wr_err  = pipe_err[RD_LAT-2];
        end
    endgenerate

    // FIFO storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge ACLK) begin
        if (fifo_wr_en) begin
            fifo_data[wr_ptr] <= fifo_wr_data;
            fifo_err[wr_ptr]  <= fifo_wr_err;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rsp_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (fifo_wr_en && !rsp_fire) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (!fifo_wr_en && rsp_fire) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

    // Outputs are forced to zero whenever no response is present.
    assign rsp_valid_int = (fifo_cnt != '0);
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_rdata = rsp_valid_int ? fifo_data[rd_ptr] : '0;
    assign bus.rsp_err   = rsp_valid_int && fifo_err[rd_ptr];

endmodule

// File: tb/tb_mem_bank_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_bank_pipe
// Self-checking bench for mem_bank_pipe. Two instances:
//   dut_a : DEPTH=1000, RD_LAT=3, RSP_DEPTH=4 (range errors, backpressure,
//           streaming, mid-operation reset)
//   dut_b : DEPTH=1024, RD_LAT=1, RSP_DEPTH=3 (non power-of-two FIFO wrap)
// Expected read responses are queued when a read is accepted and compared
// in order when the DUT hands a response over.
// ---------------------------------------------------------------------------
module tb_mem_bank_pipe;

    logic aclk;
    logic aresetn;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cnt = 0;
    int   rsp_cnt_a = 0;
    int   rsp_cnt_b = 0;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q_a[$];
    rsp_t exp_q_b[$];
    rsp_t ea;
    rsp_t eb;
    vec_t tbl [14];

    mem_bank_pipe_if #(.DATA_W(32), .ADDR_W(10)) bus_a ();
    mem_bank_pipe_if #(.DATA_W(32), .ADDR_W(10)) bus_b ();

    mem_bank_pipe #(
        .DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(3), .RSP_DEPTH(4)
    ) dut_a (
        .ACLK(aclk), .ARESETn(aresetn), .bus(bus_a)
    );

    mem_bank_pipe #(
        .DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1), .RSP_DEPTH(3)
    ) dut_b (
        .ACLK(aclk), .ARESETn(aresetn), .bus(bus_b)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    // Fill pattern used for the bulk write/read phases.
    function automatic logic [31:0] patt(input int a);
        return 32'hC3000000 ^ (a * 32'h00010101);
    endfunction

    function automatic vec_t wr(input int a, input logic [31:0] d, input logic [3:0] s);
        vec_t v;
        v.we = 1'b1; v.addr = 10'(a); v.wdata = d; v.wstrb = s;
        v.exp_rdata = '0; v.exp_err = 1'b0;
        return v;
    endfunction

    function automatic vec_t rd(input int a, input logic [31:0] d, input logic e);
        vec_t v;
        v.we = 1'b0; v.addr = 10'(a); v.wdata = '0; v.wstrb = '0;
        v.exp_rdata = d; v.exp_err = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Drive one request (called just after a rising edge), hold it until
    // accepted, and queue the expected response for reads.
    task automatic applyStimulus(input bit on_b, input vec_t v);
        bit   acc = 1'b0;
        rsp_t e;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        if (on_b) begin
            bus_b.req_valid = 1'b1; bus_b.req_we = v.we; bus_b.req_addr = v.addr;
            bus_b.req_wdata = v.wdata; bus_b.req_wstrb = v.wstrb;
        end else begin
            bus_a.req_valid = 1'b1; bus_a.req_we = v.we; bus_a.req_addr = v.addr;
            bus_a.req_wdata = v.wdata; bus_a.req_wstrb = v.wstrb;
        end
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge aclk);
            if (on_b ? bus_b.req_ready : bus_a.req_ready) begin
                acc = 1'b1;
                accept_cnt++;
                if (!v.we) begin
                    if (on_b) exp_q_b.push_back(e);
                    else      exp_q_a.push_back(e);
                end
            end
            @(posedge aclk);
            #1;
        end
        if (on_b) bus_b.req_valid = 1'b0;
        else      bus_a.req_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: addr=%0d not accepted", v.addr);
        end
    endtask

    // Wait (bounded) until every queued response has been returned.
    task automatic waitDrain(input string name);
        int n = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < 300) begin
            @(posedge aclk);
            n++;
        end
        #1;
        checkOutput(name, exp_q_a.size() + exp_q_b.size(), 0);
    endtask

    // Response monitors: compare at the negedge before the consuming edge.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && bus_a.rsp_valid === 1'b1 && bus_a.rsp_ready === 1'b1) begin
            rsp_cnt_a++;
            if (exp_q_a.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp_a: rdata=0x%08h none expected", bus_a.rsp_rdata);
            end else begin
                ea = exp_q_a.pop_front();
                checkOutput("rsp_a_rdata", bus_a.rsp_rdata, ea.rdata);
                checkOutput("rsp_a_err", 32'(bus_a.rsp_err), 32'(ea.err));
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && bus_b.rsp_valid === 1'b1 && bus_b.rsp_ready === 1'b1) begin
            rsp_cnt_b++;
            if (exp_q_b.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp_b: rdata=0x%08h none expected", bus_b.rsp_rdata);
            end else begin
                eb = exp_q_b.pop_front();
                checkOutput("rsp_b_rdata", bus_b.rsp_rdata, eb.rdata);
                checkOutput("rsp_b_err", 32'(bus_b.rsp_err), 32'(eb.err));
            end
        end
    end

    // Absolute watchdog in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int start;
        int seen;

        tbl = '{
            wr(5,    32'hAABBCCDD, 4'b1111),
            rd(5,    32'hAABBCCDD, 1'b0),
            wr(5,    32'h11223344, 4'b0101),
            rd(5,    32'hAA22CC44, 1'b0),
            rd(1023, 32'h00000000, 1'b1),
            wr(1023, 32'hDEADBEEF, 4'b1111),
            rd(1023, 32'h00000000, 1'b1),
            wr(999,  32'h12345678, 4'b1111),
            rd(999,  32'h12345678, 1'b0),
            wr(1000, 32'hCAFEF00D, 4'b1111),
            rd(1000, 32'h00000000, 1'b1),
            wr(0,    32'h01020304, 4'b1111),
            wr(0,    32'hA0B0C0D0, 4'b1010),
            rd(0,    32'hA002C004, 1'b0)
        };

        aresetn = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
        bus_a.req_wdata = '0; bus_a.req_wstrb = '0; bus_a.rsp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
        bus_b.req_wdata = '0; bus_b.req_wstrb = '0; bus_b.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst_req_ready_a", 32'(bus_a.req_ready), 0);
        checkOutput("rst_rsp_valid_a", 32'(bus_a.rsp_valid), 0);
        checkOutput("rst_rsp_rdata_a", bus_a.rsp_rdata, 0);
        checkOutput("rst_rsp_err_a", 32'(bus_a.rsp_err), 0);
        checkOutput("rst_req_ready_b", 32'(bus_b.req_ready), 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checkOutput("ready_after_rst_a", 32'(bus_a.req_ready), 1);
        checkOutput("ready_after_rst_b", 32'(bus_b.req_ready), 1);

        // Table-driven writes/reads including range boundaries
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, tbl[i]);
        waitDrain("drain_table");

        // Latency with an empty FIFO: response visible in cycle T+3
        applyStimulus(1'b0, rd(5, 32'hAA22CC44, 1'b0));
        @(negedge aclk);
        checkOutput("lat_t1_valid", 32'(bus_a.rsp_valid), 0);
        @(negedge aclk);
        checkOutput("lat_t2_valid", 32'(bus_a.rsp_valid), 0);
        @(negedge aclk);
        checkOutput("lat_t3_valid", 32'(bus_a.rsp_valid), 1);
        @(posedge aclk);
        #1;
        waitDrain("drain_latency");

        // Prefill addresses 100..199
        for (int i = 100; i < 200; i++) applyStimulus(1'b0, wr(i, patt(i), 4'b1111));

        // Backpressure: only RSP_DEPTH reads accepted while rsp_ready=0
        bus_a.rsp_ready = 1'b0;
        base = accept_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(1'b0, rd(100 + i, patt(100 + i), 1'b0));
            end
            begin
                repeat (12) @(negedge aclk);
                checkOutput("bp_accepted", 32'(accept_cnt - base), 4);
                checkOutput("bp_req_ready", 32'(bus_a.req_ready), 0);
                checkOutput("bp_rsp_valid", 32'(bus_a.rsp_valid), 1);
                checkOutput("bp_hold_rdata", bus_a.rsp_rdata, patt(100));
                @(negedge aclk);
                checkOutput("bp_stable_valid", 32'(bus_a.rsp_valid), 1);
                checkOutput("bp_stable_rdata", bus_a.rsp_rdata, patt(100));
                checkOutput("bp_stable_err", 32'(bus_a.rsp_err), 0);
                @(posedge aclk);
                #1;
                bus_a.rsp_ready = 1'b1;
            end
        join
        waitDrain("drain_backpressure");
        checkOutput("bp_total_accepted", 32'(accept_cnt - base), 6);

        // Streaming 100 reads at one per cycle
        base = rsp_cnt_a;
        start = cyc;
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, rd(100 + i, patt(100 + i), 1'b0));
        checkOutput("stream_cycles", 32'(cyc - start), 100);
        waitDrain("drain_stream");
        checkOutput("stream_rsp_count", 32'(rsp_cnt_a - base), 100);

        // Reset with three reads outstanding
        bus_a.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, rd(110 + i, patt(110 + i), 1'b0));
        repeat (5) @(posedge aclk);
        #3;
        checkOutput("pre_rst_rsp_valid", 32'(bus_a.rsp_valid), 1);
        aresetn = 1'b0;
        #1;
        checkOutput("midrst_req_ready", 32'(bus_a.req_ready), 0);
        checkOutput("midrst_rsp_valid", 32'(bus_a.rsp_valid), 0);
        checkOutput("midrst_rsp_rdata", bus_a.rsp_rdata, 0);
        checkOutput("midrst_rsp_err", 32'(bus_a.rsp_err), 0);
        exp_q_a.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        bus_a.rsp_ready = 1'b1;
        @(posedge aclk);
        #1;
        checkOutput("postrst_req_ready", 32'(bus_a.req_ready), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (bus_a.rsp_valid !== 1'b0) seen++;
        end
        checkOutput("postrst_no_stale", 32'(seen), 0);
        @(posedge aclk);
        #1;

        // dut_b: non power-of-two FIFO depth, streaming and random backpressure
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, wr(i, patt(i), 4'b1111));
        start = cyc;
        base = rsp_cnt_b;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, rd(i, patt(i), 1'b0));
        checkOutput("b_stream_cycles", 32'(cyc - start), 20);
        waitDrain("drain_b_stream");
        fork
            begin
                for (int i = 0; i < 20; i++) applyStimulus(1'b1, rd(19 - i, patt(19 - i), 1'b0));
            end
            begin
                repeat (60) begin
                    @(posedge aclk);
                    #1;
                    bus_b.rsp_ready = 1'($urandom_range(0, 1));
                end
                bus_b.rsp_ready = 1'b1;
            end
        join
        waitDrain("drain_b_random");
        checkOutput("b_rsp_count", 32'(rsp_cnt_b - base), 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bank_pipe.md
MEM_BANK_PIPE -- requirements
Module: mem_bank_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words, 1..2^ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles, 1..4.
REQ-005 SHALL have parameter RSP_DEPTH, default 4, max outstanding reads, at least 1.
REQ-006 SHALL have port ACLK, input, 1, sole clock, rising edge.
REQ-007 SHALL have port ARESETn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, request may be accepted.
REQ-010 SHALL have port req_we, input, 1, 1=write, 0=read.
REQ-011 SHALL have port req_addr, input, ADDR_W, word address.
REQ-012 SHALL have port req_wdata, input, DATA_W, write data.
REQ-013 SHALL have port req_wstrb, input, DATA_W/8, byte write enables.
REQ-014 SHALL have port rsp_valid, output, 1, read response present.
REQ-015 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-016 SHALL have port rsp_rdata, output, DATA_W, read data.
REQ-017 SHALL have port rsp_err, output, 1, read address was >= DEPTH.

Function
REQ-018 SHALL accept a request on a rising ACLK edge where req_valid and req_ready are both 1.
REQ-019 SHALL drive req_ready = (outstanding < RSP_DEPTH), independent of req_valid and req_we.
REQ-020 SHALL track outstanding reads: +1 per accepted read, -1 per rsp handshake (rsp_valid and rsp_ready), unchanged when both occur in the same cycle.
REQ-021 SHALL, on an accepted write with addr < DEPTH, update only the bytes whose req_wstrb bit is 1, at that edge.
REQ-022 SHALL ignore writes with addr >= DEPTH, leave memory unchanged, and produce no response.
REQ-023 SHALL produce no response for any write; only reads produce responses.
REQ-024 SHALL sample memory for a read at its accept edge; a read accepted the cycle after a write to the same address returns the updated data.
REQ-025 SHALL return rdata=0 and rsp_err=1 for a read with addr >= DEPTH, and rsp_err=0 otherwise.
REQ-026 SHALL carry read data through an RD_LAT-stage pipeline into a response FIFO of RSP_DEPTH entries.
REQ-027 SHALL, when a read is accepted at cycle T and the FIFO is empty, assert rsp_valid with its data during cycle T+RD_LAT.
REQ-028 SHALL return responses in request order, one per accepted read, with no loss or duplication.
REQ-029 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-030 SHALL sustain one read per cycle when rsp_ready stays 1 and RSP_DEPTH >= RD_LAT+1.
REQ-031 SHALL never overflow the FIFO; the outstanding limit guarantees space for every read in flight.
REQ-032 SHALL handle FIFO pointer wrap-around for any RSP_DEPTH, including values that are not powers of two.

Reset
REQ-033 SHALL, while ARESETn=0: drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; clear outstanding, the pipeline valids and the FIFO pointers.
REQ-034 SHALL leave memory array contents uninitialised and unaffected by reset.
REQ-035 SHALL discard all in-flight reads when reset is asserted mid-operation; no stale response appears after release.
REQ-036 SHALL drive req_ready=1 from the first rising edge after ARESETn deasserts.

Verification
REQ-037 Write addr 5 = 0xAABBCCDD with wstrb 1111, then read addr 5 -> rsp_rdata 0xAABBCCDD, rsp_err 0, rsp_valid in cycle T+RD_LAT.
REQ-038 Write 0x11223344 with wstrb 0101 over an address holding 0xAABBCCDD -> read returns 0xAA22CC44.
REQ-039 Read addr 1023 with DEPTH=1000 -> rsp_rdata 0, rsp_err 1; a write to 1023 leaves memory unchanged.
REQ-040 RD_LAT=3, RSP_DEPTH=4, rsp_ready held 0, 6 back-to-back reads -> exactly 4 accepted, req_ready 0; release rsp_ready -> 4 in-order responses, then the remaining 2 are accepted.
REQ-041 Stream 100 reads with rsp_ready=1 and RSP_DEPTH=RD_LAT+1 -> one response per cycle, in order, with FIFO wrap exercised.
REQ-042 Assert ARESETn=0 with 3 reads outstanding -> all outputs 0 immediately; after release, no response appears and req_ready=1.
